// File: rtl/ex_pkg.sv
// Shared definitions for the RV32IM execute stage: ALU opcodes, divider
// state encoding and control-bus bit positions.
package ex_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_PASSB  = 5'd10;
  localparam logic [4:0] ALU_MUL    = 5'd11;
  localparam logic [4:0] ALU_MULH   = 5'd12;
  localparam logic [4:0] ALU_MULHSU = 5'd13;
  localparam logic [4:0] ALU_MULHU  = 5'd14;
  localparam logic [4:0] ALU_DIV    = 5'd16;
  localparam logic [4:0] ALU_DIVU   = 5'd17;
  localparam logic [4:0] ALU_REM    = 5'd18;
  localparam logic [4:0] ALU_REMU   = 5'd19;

  localparam int MEMREAD  = 4;
  localparam int MEMWRITE = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_if.sv
// Decode-to-EX inputs and EX/MEM register outputs of the execute stage.
interface ex_if;

  logic        valid_ex;
  logic        flush_ex;
  logic [4:0]  alu_op;
  logic        alu_src;
  logic [4:0]  ctrl_ex;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [31:0] pc4_ex;
  logic [4:0]  rd_ex;

  logic        stall_ex;
  logic [4:0]  ctrl_mem;
  logic [31:0] rd_mem;
  logic [31:0] pc4_mem;
  logic [31:0] alu_result;
  logic [31:0] write_data;

  modport master (
    output valid_ex, flush_ex, alu_op, alu_src, ctrl_ex,
           rs1_data, rs2_data, imm, pc4_ex, rd_ex,
    input  stall_ex, ctrl_mem, rd_mem, pc4_mem, alu_result, write_data
  );

  modport slave (
    input  valid_ex, flush_ex, alu_op, alu_src, ctrl_ex,
           rs1_data, rs2_data, imm, pc4_ex, rd_ex,
    output stall_ex, ctrl_mem, rd_mem, pc4_mem, alu_result, write_data
  );

endinterface

// File: rtl/div_iter.sv
// Restoring unsigned 32/32 divider, one quotient bit per cycle over 32 cycles.
module div_iter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        busy_q, busy_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] rem_shift;
  logic [32:0] diff;

  always_comb begin
    busy_d    = busy_q;
    count_d   = count_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    // The dividend shifts out of quo_q MSB-first while quotient bits fill in at the LSB.
    rem_shift = {rem_q, quo_q[31]};
    diff      = rem_shift - {1'b0, dvs_q};
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d  = 1'b1;
      count_d = 5'd0;
      quo_d   = dividend;
      rem_d   = 32'd0;
      dvs_d   = divisor;
    end else if (busy_q) begin
      if (diff[32]) begin
        rem_d = rem_shift[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end else begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end
      count_d = count_q + 5'd1;
      if (count_q == 5'd31) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= 1'b0;
      count_q <= 5'd0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    quo_q <= quo_d;
    rem_q <= rem_d;
    dvs_q <= dvs_d;
  end

  assign busy      = busy_q;
  assign done      = busy_q && (count_q == 5'd31);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: single-cycle ALU/multiplier, iterative divider with
// front-end stall, and the EX/MEM pipeline register.
module ex_stage
  import ex_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  ex_if.slave  bus
);

  div_state_e  state_q, state_d;
  logic [31:0] op_a, op_b;
  logic [4:0]  op;
  logic        div_signed, b_zero, ovf, special, div_req, start, stall, load;
  logic [31:0] a_mag, b_mag;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic        div_busy, div_done;
  logic [31:0] div_quo, div_rem, quo_fix, rem_fix;
  logic signed [63:0] mul_a, mul_b, prod;
  logic [31:0] result;

  logic [4:0]  ctrl_q, ctrl_d;
  logic [31:0] rd_q, rd_d, pc4_q, pc4_d, res_q, res_d, wd_q, wd_d;

  assign op         = bus.alu_op;
  assign op_a       = bus.rs1_data;
  assign op_b       = bus.alu_src ? bus.imm : bus.rs2_data;
  assign div_signed = (op == ALU_DIV) || (op == ALU_REM);
  assign b_zero     = (op_b == 32'd0);
  assign ovf        = div_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  assign special    = b_zero || ovf;
  assign div_req    = bus.valid_ex && is_div_op(op) && !special;
  assign start      = (state_q == ST_IDLE) && div_req && !bus.flush_ex;
  assign stall      = !bus.flush_ex &&
                      (((state_q == ST_IDLE) && div_req) || (state_q == ST_DIV));
  assign a_mag      = (div_signed && op_a[31]) ? -op_a : op_a;
  assign b_mag      = (div_signed && op_b[31]) ? -op_b : op_b;
  assign neg_quo_d  = start ? (div_signed && (op_a[31] ^ op_b[31])) : neg_quo_q;
  assign neg_rem_d  = start ? (div_signed && op_a[31]) : neg_rem_q;
  assign quo_fix    = neg_quo_q ? -div_quo : div_quo;
  assign rem_fix    = neg_rem_q ? -div_rem : div_rem;

  div_iter u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (bus.flush_ex),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d = state_q;
    if (bus.flush_ex) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_DIV;
        ST_DIV:  if (div_done) state_d = ST_DONE;
                 else if (!div_busy) state_d = ST_IDLE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // High-half products come from sign- or zero-extending each operand to 64 bits.
  assign mul_a = {{32{((op == ALU_MULH) || (op == ALU_MULHSU)) && op_a[31]}}, op_a};
  assign mul_b = {{32{(op == ALU_MULH) && op_b[31]}}, op_b};
  assign prod  = mul_a * mul_b;

  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:    result = op_a + op_b;
      ALU_SUB:    result = op_a - op_b;
      ALU_SLL:    result = op_a << op_b[4:0];
      ALU_SLT:    result = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   result = {31'd0, op_a < op_b};
      ALU_XOR:    result = op_a ^ op_b;
      ALU_SRL:    result = op_a >> op_b[4:0];
      ALU_SRA:    result = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_OR:     result = op_a | op_b;
      ALU_AND:    result = op_a & op_b;
      ALU_PASSB:  result = op_b;
      ALU_MUL:    result = prod[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prod[63:32];
      ALU_DIV, ALU_DIVU: result = b_zero ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : quo_fix);
      ALU_REM, ALU_REMU: result = b_zero ? op_a : (ovf ? 32'd0 : rem_fix);
      default:    result = 32'd0;
    endcase
  end

  // EX/MEM register: stalls, bubbles and flushes all load zeros.
  assign load   = bus.valid_ex && !stall && !bus.flush_ex;
  assign ctrl_d = load ? bus.ctrl_ex : 5'd0;
  assign rd_d   = load ? {27'd0, bus.rd_ex} : 32'd0;
  assign pc4_d  = load ? bus.pc4_ex : 32'd0;
  assign res_d  = load ? result : 32'd0;
  assign wd_d   = load ? bus.rs2_data : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ctrl_q  <= 5'd0;
      rd_q    <= 32'd0;
      pc4_q   <= 32'd0;
      res_q   <= 32'd0;
      wd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      pc4_q   <= pc4_d;
      res_q   <= res_d;
      wd_q    <= wd_d;
    end
  end

  always_ff @(posedge clk) begin
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
  end

  assign bus.stall_ex   = stall;
  assign bus.ctrl_mem   = ctrl_q;
  assign bus.rd_mem     = rd_q;
  assign bus.pc4_mem    = pc4_q;
  assign bus.alu_result = res_q;
  assign bus.write_data = wd_q;

endmodule
